// File: rtl/n25q_seq.sv
// N25Q command sequencer: turns host READ / PAGE PROGRAM requests into shifter word phases.
// Optional: `define N25Q_SEQ_FAST_READ_EN selects FAST READ (0x0B plus one dummy byte).
module n25q_seq #(
    parameter int unsigned CS_GAP   = 4,
    parameter int unsigned POLL_MAX = 200000
) (
    input  logic        ifclk,
    input  logic        resetb,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_prog,
    input  logic [23:0] cmd_addr,
    input  logic [8:0]  cmd_len,
    input  logic [7:0]  wr_data,
    input  logic        wr_valid,
    output logic        wr_ready,
    output logic [7:0]  rd_data,
    output logic        rd_valid,
    input  logic        rd_ready,
    output logic        done,
    output logic [1:0]  err,
    output logic        csb_req,
    output logic        n25q_write_mode,
    output logic        n25q_read_mode,
    output logic        n25q_write,
    output logic        n25q_read_req,
    output logic [31:0] n25q_len,
    output logic [31:0] n25q_datai,
    input  logic        n25q_rdy,
    input  logic [31:0] n25q_datao
);

    // state    | meaning
    // IDLE     | waiting for a host command
    // WREN     | 1-byte WRITE ENABLE phase
    // CMD      | opcode + address word (plus dummy word for fast read)
    // DATA_W   | packing host bytes into program words
    // DATA_R   | unpacking flash words to the host
    // POLL     | READ STATUS: opcode word, then status byte
    // GAP      | csb high for CS_GAP cycles between phases
    // FINISH   | done pulse, back to IDLE
    typedef enum logic [2:0] {
        S_IDLE, S_WREN, S_CMD, S_DATA_W, S_DATA_R, S_POLL, S_GAP, S_FINISH
    } state_t;

`ifdef N25Q_SEQ_FAST_READ_EN
    localparam logic       FAST  = 1'b1;
    localparam logic [7:0] RD_OP = 8'h0B;
`else
    localparam logic       FAST  = 1'b0;
    localparam logic [7:0] RD_OP = 8'h03;
`endif

    state_t      state, next_state, ret;
    logic [1:0]  step, cmd_last;
    logic        alive, hold, prog, rd_wait;
    logic        sh_idle, len_bad, cmd_acc, wr_acc, rd_acc, poll_done;
    logic [23:0] addr;
    logic [8:0]  len, cnt;
    logic [2:0]  wcnt, rcnt;
    logic [31:0] wbuf, rbuf, gap_cnt, poll_left;

    // the shifter's rdy is not trusted in the cycle right after a pulse
    assign sh_idle   = !hold && n25q_rdy;
    assign len_bad   = (cmd_len == 9'd0) || (cmd_len > 9'd256);
    assign cmd_acc   = cmd_valid && cmd_ready;
    assign wr_acc    = wr_valid && wr_ready;
    assign rd_acc    = rd_valid && rd_ready;
    assign cmd_last  = (FAST && !prog) ? 2'd3 : 2'd1;
    assign poll_done = (state == S_POLL) && (step == 2'd3) && sh_idle;

    always_ff @(posedge ifclk or negedge resetb) begin
        if (!resetb) state <= S_IDLE;
        else         state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:   if (cmd_acc) next_state = len_bad ? S_FINISH : (cmd_prog ? S_WREN : S_CMD);
            S_WREN:   if (step == 2'd1 && sh_idle) next_state = S_GAP;
            S_CMD:    if (step == cmd_last && sh_idle) next_state = prog ? S_DATA_W : S_DATA_R;
            S_DATA_W: if (cnt == 9'd0 && wcnt == 3'd0 && sh_idle) next_state = S_GAP;
            S_DATA_R: if (cnt == 9'd0 && !rd_wait && sh_idle) next_state = S_FINISH;
            S_POLL:   if (poll_done)
                          next_state = (!n25q_datao[0] || poll_left == 32'd1) ? S_FINISH : S_GAP;
            S_GAP:    if (gap_cnt == 32'd0) next_state = ret;
            S_FINISH: next_state = S_IDLE;
            default:  next_state = S_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready       = alive && (state == S_IDLE);
        wr_ready        = (state == S_DATA_W) && (wcnt != 3'd4) && (cnt != 9'd0);
        rd_valid        = (state == S_DATA_R) && (rcnt != 3'd0);
        rd_data         = rbuf[7:0];
        done            = (state == S_FINISH);
        csb_req         = 1'b1;
        n25q_write_mode = 1'b0;
        n25q_read_mode  = 1'b0;
        n25q_write      = 1'b0;
        n25q_read_req   = 1'b0;
        n25q_len        = 32'd0;
        n25q_datai      = 32'd0;
        case (state)
            S_WREN: begin
                csb_req         = 1'b0;
                n25q_write_mode = 1'b1;
                n25q_write      = sh_idle && (step == 2'd0);
                n25q_len        = 32'd1;
                n25q_datai      = 32'h0000_0006;
            end
            S_CMD: begin
                csb_req         = 1'b0;
                n25q_write_mode = 1'b1;
                n25q_write      = sh_idle && (step == 2'd0 || step == 2'd2);
                n25q_len        = 32'(len) + (prog ? 32'd4 : 32'd4 + 32'(FAST));
                n25q_datai      = (step < 2'd2) ?
                                  {addr[7:0], addr[15:8], addr[23:16], prog ? 8'h02 : RD_OP} :
                                  32'h0000_00FF;
            end
            S_DATA_W: begin
                csb_req         = 1'b0;
                n25q_write_mode = 1'b1;
                n25q_write      = sh_idle && ((wcnt == 3'd4) || (cnt == 9'd0 && wcnt != 3'd0));
                n25q_len        = 32'(len) + 32'd4;
                n25q_datai      = wbuf;
            end
            S_DATA_R: begin
                csb_req         = 1'b0;
                n25q_read_mode  = 1'b1;
                n25q_read_req   = sh_idle && (rcnt == 3'd0) && !rd_wait && (cnt != 9'd0);
                n25q_len        = 32'(len) + 32'd4 + 32'(FAST);
                n25q_datai      = 32'hFFFF_FFFF;
            end
            S_POLL: begin
                csb_req         = 1'b0;
                n25q_write_mode = (step < 2'd2);
                n25q_read_mode  = (step >= 2'd2);
                n25q_write      = sh_idle && (step == 2'd0);
                n25q_read_req   = sh_idle && (step == 2'd2);
                n25q_len        = 32'd2;
                n25q_datai      = (step < 2'd2) ? 32'h0000_0005 : 32'hFFFF_FFFF;
            end
            default: ;
        endcase
    end

    always_ff @(posedge ifclk or negedge resetb) begin
        if (!resetb) begin
            alive     <= 1'b0;
            hold      <= 1'b0;
            prog      <= 1'b0;
            rd_wait   <= 1'b0;
            addr      <= '0;
            len       <= '0;
            cnt       <= '0;
            wcnt      <= '0;
            rcnt      <= '0;
            wbuf      <= '0;
            rbuf      <= '0;
            gap_cnt   <= '0;
            poll_left <= '0;
            step      <= '0;
            ret       <= S_IDLE;
            err       <= 2'd0;
        end else begin
            alive <= 1'b1;
            hold  <= n25q_write | n25q_read_req;
            if (cmd_acc) begin
                prog    <= cmd_prog;
                addr    <= cmd_addr;
                len     <= cmd_len;
                cnt     <= cmd_len;
                wcnt    <= '0;
                rcnt    <= '0;
                wbuf    <= '0;
                rd_wait <= 1'b0;
                err     <= len_bad ? 2'd1 : 2'd0;
            end
            if (next_state != state)
                step <= '0;
            else if (sh_idle && step != 2'd3 &&
                     (state == S_WREN || state == S_CMD || state == S_POLL))
                step <= step + 2'd1;
            if (wr_acc) begin
                wbuf[{wcnt[1:0], 3'b000} +: 8] <= wr_data;
                wcnt <= wcnt + 3'd1;
                cnt  <= cnt - 9'd1;
            end
            if (state == S_DATA_W && n25q_write) begin
                wbuf <= '0;
                wcnt <= '0;
            end
            if (state == S_DATA_R && n25q_read_req) rd_wait <= 1'b1;
            if (state == S_DATA_R && rd_wait && sh_idle) begin
                rbuf    <= n25q_datao;
                rcnt    <= (cnt > 9'd4) ? 3'd4 : cnt[2:0];
                rd_wait <= 1'b0;
            end
            if (rd_acc) begin
                rbuf <= {8'h00, rbuf[31:8]};
                rcnt <= rcnt - 3'd1;
                cnt  <= cnt - 9'd1;
            end
            if (next_state == S_GAP && state != S_GAP) begin
                gap_cnt <= 32'(CS_GAP - 1);
                ret     <= (state == S_WREN) ? S_CMD : S_POLL;
            end else if (state == S_GAP && gap_cnt != 32'd0) begin
                gap_cnt <= gap_cnt - 32'd1;
            end
            if (state == S_DATA_W && next_state == S_GAP) poll_left <= 32'(POLL_MAX);
            if (poll_done) begin
                poll_left <= poll_left - 32'd1;
                if (n25q_datao[0] && poll_left == 32'd1) err <= 2'd2;
            end
        end
    end

endmodule

// File: tb/tb_n25q_seq.sv
// Directed bench for n25q_seq with a behavioural shifter/flash model.
`timescale 1ns/1ps
module tb_n25q_seq;

    logic        ifclk = 1'b0;
    logic        resetb = 1'b0;
    logic        cmd_valid = 1'b0, cmd_ready, cmd_prog = 1'b0;
    logic [23:0] cmd_addr = '0;
    logic [8:0]  cmd_len = '0;
    logic [7:0]  wr_data = '0;
    logic        wr_valid = 1'b0, wr_ready;
    logic [7:0]  rd_data;
    logic        rd_valid, rd_ready = 1'b1;
    logic        done;
    logic [1:0]  err;
    logic        csb_req, n25q_write_mode, n25q_read_mode, n25q_write, n25q_read_req;
    logic [31:0] n25q_len, n25q_datai, n25q_datao;
    logic        n25q_rdy;

    n25q_seq #(.CS_GAP(4), .POLL_MAX(10)) dut (
        .ifclk(ifclk), .resetb(resetb),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_prog(cmd_prog),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .done(done), .err(err), .csb_req(csb_req),
        .n25q_write_mode(n25q_write_mode), .n25q_read_mode(n25q_read_mode),
        .n25q_write(n25q_write), .n25q_read_req(n25q_read_req),
        .n25q_len(n25q_len), .n25q_datai(n25q_datai),
        .n25q_rdy(n25q_rdy), .n25q_datao(n25q_datao)
    );

    always #5 ifclk = ~ifclk;

    int checks = 0;
    int errors = 0;

    logic [31:0] wq[$];
    logic [31:0] lq[$];
    logic [7:0]  rq[$];
    int          rdq_cons[$];
    int falls = 0, min_gap = 1000, gap_run = 0, done_cnt = 0, proto_err = 0;
    int poll_n = 0, rd_pulses = 0, wr_acc_cnt = 0, wip_busy = 2, busy = 0;
    logic        csb_q = 1'b1, first_w = 1'b1, len_set = 1'b0;
    logic [7:0]  cur_op = '0;
    logic [23:0] rptr = '0;
    logic [31:0] phase_len_v = '0;

    function automatic logic [7:0] mem(input logic [23:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    // shifter + flash model and protocol monitor
    always @(posedge ifclk or negedge resetb) begin
        if (!resetb) begin
            n25q_rdy   <= 1'b1;
            n25q_datao <= '0;
            busy    = 0;
            first_w = 1'b1;
            len_set = 1'b0;
        end else begin
            if (done) done_cnt++;
            if (rd_valid && rd_ready) rq.push_back(rd_data);
            if (wr_valid && wr_ready) wr_acc_cnt++;
            if (csb_q && !csb_req) begin
                falls++;
                if (falls > 1 && gap_run < min_gap) min_gap = gap_run;
            end
            gap_run = csb_req ? gap_run + 1 : 0;
            csb_q = csb_req;
            if (csb_req) begin
                first_w = 1'b1;
                len_set = 1'b0;
            end
            if (n25q_write || n25q_read_req) begin
                if (n25q_write && n25q_read_req) proto_err++;
                if (!n25q_rdy || csb_req) proto_err++;
                if (n25q_write && !(n25q_write_mode && !n25q_read_mode)) proto_err++;
                if (n25q_read_req && !(n25q_read_mode && !n25q_write_mode)) proto_err++;
                if (len_set && n25q_len != phase_len_v) proto_err++;
                phase_len_v = n25q_len;
                len_set = 1'b1;
                busy = 3;
                n25q_rdy <= 1'b0;
            end else if (busy > 0) begin
                busy--;
                if (busy == 0) n25q_rdy <= 1'b1;
            end
            if (n25q_write) begin
                wq.push_back(n25q_datai);
                lq.push_back(n25q_len);
                if (first_w) begin
                    cur_op  = n25q_datai[7:0];
                    rptr    = {n25q_datai[15:8], n25q_datai[23:16], n25q_datai[31:24]};
                    first_w = 1'b0;
                end
            end
            if (n25q_read_req) begin
                rd_pulses++;
                if (cur_op == 8'h03) begin
                    rdq_cons.push_back(rq.size());
                    n25q_datao <= {mem(rptr + 24'd3), mem(rptr + 24'd2), mem(rptr + 24'd1), mem(rptr)};
                    rptr = rptr + 24'd4;
                end else if (cur_op == 8'h05) begin
                    poll_n++;
                    n25q_datao <= (poll_n <= wip_busy) ? 32'h1 : 32'h0;
                end
            end
        end
    end

    task automatic clear_logs;
        wq.delete(); lq.delete(); rq.delete(); rdq_cons.delete();
        falls = 0; min_gap = 1000; done_cnt = 0; proto_err = 0;
        poll_n = 0; rd_pulses = 0; wr_acc_cnt = 0;
    endtask

    task automatic send_cmd(input logic prog, input logic [23:0] a, input logic [8:0] l);
        for (int i = 0; i < 50; i++) begin
            @(negedge ifclk);
            if (cmd_ready) break;
        end
        cmd_valid = 1'b1; cmd_prog = prog; cmd_addr = a; cmd_len = l;
        @(negedge ifclk);
        cmd_valid = 1'b0;
    endtask

    task automatic run(input int budget, input int nbytes, input logic [7:0] base,
                       input logic toggle_rd, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (nbytes > 0) begin
                wr_valid = 1'b1;
                wr_data  = (wr_acc_cnt < nbytes) ? base + 8'(wr_acc_cnt) : 8'hEE;
            end
            rd_ready = toggle_rd ? ~rd_ready : 1'b1;
            @(negedge ifclk);
            if (done_cnt > 0) begin
                ok = 1'b1;
                break;
            end
        end
        wr_valid = 1'b0;
        rd_ready = 1'b1;
    endtask

    task automatic test_reset;
        resetb = 1'b0;
        repeat (3) @(negedge ifclk);
        checks++;
        if (cmd_ready !== 1'b0) begin errors++; $display("FAIL reset_cmd_ready got %b want 0", cmd_ready); end
        checks++;
        if ({csb_req, wr_ready, rd_valid, done, n25q_write_mode, n25q_read_mode, n25q_write, n25q_read_req} !== 8'b1000_0000) begin
            errors++;
            $display("FAIL reset_ctrl got %b want 10000000",
                     {csb_req, wr_ready, rd_valid, done, n25q_write_mode, n25q_read_mode, n25q_write, n25q_read_req});
        end
        checks++;
        if ({err, rd_data, n25q_len, n25q_datai} !== 74'd0) begin
            errors++; $display("FAIL reset_data got err=%0d rd=%h len=%h di=%h want 0", err, rd_data, n25q_len, n25q_datai);
        end
        resetb = 1'b1;
        @(negedge ifclk);
        checks++;
        if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready got %b want 1", cmd_ready); end
    endtask

    task automatic test_read;
        logic ok;
        clear_logs();
        send_cmd(1'b0, 24'h123456, 9'd6);
        run(2000, 0, 8'h00, 1'b0, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL read_done timeout got done_cnt=%0d want 1", done_cnt); end
        checks++;
        if (done_cnt != 1 || err !== 2'd0) begin errors++; $display("FAIL read_status got done=%0d err=%0d want 1/0", done_cnt, err); end
        checks++;
        if (falls != 1) begin errors++; $display("FAIL read_csb_phases got %0d want 1", falls); end
        checks++;
        if (wq.size() != 1 || wq[0] !== 32'h5634_1203 || lq[0] !== 32'd10) begin
            errors++; $display("FAIL read_cmd_word got n=%0d w=%h len=%0d want 1/56341203/10", wq.size(), wq[0], lq[0]);
        end
        checks++;
        if (rq.size() != 6) begin errors++; $display("FAIL read_count got %0d want 6", rq.size()); end
        else begin
            checks++;
            if (rq[0] !== 8'h38) begin errors++; $display("FAIL read_first_byte got %h want 38", rq[0]); end
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (rq[i] !== mem(24'h123456 + 24'(i))) begin
                    errors++; $display("FAIL read_byte%0d got %h want %h", i, rq[i], mem(24'h123456 + 24'(i)));
                end
            end
        end
        checks++;
        if (proto_err != 0) begin errors++; $display("FAIL read_protocol got %0d violations want 0", proto_err); end
    endtask

    task automatic test_program;
        logic        ok;
        logic [31:0] exp_w [7];
        logic [31:0] exp_l [7];
        exp_w = '{32'h06, 32'h0001_0002, 32'h1413_1211, 32'h0000_0015, 32'h05, 32'h05, 32'h05};
        exp_l = '{32'd1, 32'd9, 32'd9, 32'd9, 32'd2, 32'd2, 32'd2};
        clear_logs();
        wip_busy = 2;
        send_cmd(1'b1, 24'h000100, 9'd5);
        run(3000, 5, 8'h11, 1'b0, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL prog_done timeout got done_cnt=%0d want 1", done_cnt); end
        checks++;
        if (err !== 2'd0 || done_cnt != 1) begin errors++; $display("FAIL prog_status got err=%0d done=%0d want 0/1", err, done_cnt); end
        checks++;
        if (wq.size() != 7) begin errors++; $display("FAIL prog_words got %0d want 7", wq.size()); end
        else begin
            for (int i = 0; i < 7; i++) begin
                checks++;
                if (wq[i] !== exp_w[i] || lq[i] !== exp_l[i]) begin
                    errors++; $display("FAIL prog_word%0d got %h/len %0d want %h/len %0d", i, wq[i], lq[i], exp_w[i], exp_l[i]);
                end
            end
        end
        checks++;
        if (poll_n != 3 || falls != 5) begin errors++; $display("FAIL prog_polls got polls=%0d phases=%0d want 3/5", poll_n, falls); end
        checks++;
        if (min_gap < 4) begin errors++; $display("FAIL prog_gap got %0d want >=4", min_gap); end
        checks++;
        if (wr_acc_cnt != 5) begin errors++; $display("FAIL prog_bytes_accepted got %0d want 5", wr_acc_cnt); end
        checks++;
        if (proto_err != 0) begin errors++; $display("FAIL prog_protocol got %0d violations want 0", proto_err); end
    endtask

    task automatic test_bad_len;
        logic [8:0] lens [2];
        lens = '{9'd0, 9'd257};
        for (int k = 0; k < 2; k++) begin
            clear_logs();
            send_cmd(1'b0, 24'h000000, lens[k]);
            checks++;
            if (done !== 1'b1 || err !== 2'd1) begin
                errors++; $display("FAIL badlen%0d_pulse got done=%b err=%0d want 1/1", lens[k], done, err);
            end
            repeat (3) @(negedge ifclk);
            checks++;
            if (done_cnt != 1 || err !== 2'd1 || cmd_ready !== 1'b1) begin
                errors++; $display("FAIL badlen%0d_after got done_cnt=%0d err=%0d ready=%b want 1/1/1", lens[k], done_cnt, err, cmd_ready);
            end
            checks++;
            if (falls != 0 || wq.size() != 0 || rd_pulses != 0) begin
                errors++; $display("FAIL badlen%0d_traffic got phases=%0d w=%0d r=%0d want 0", lens[k], falls, wq.size(), rd_pulses);
            end
        end
    endtask

    task automatic test_poll_timeout;
        logic ok;
        clear_logs();
        wip_busy = 1000;
        send_cmd(1'b1, 24'h00ABCD, 9'd1);
        run(3000, 1, 8'h77, 1'b0, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL timeout_done timeout got done_cnt=%0d want 1", done_cnt); end
        checks++;
        if (poll_n != 10) begin errors++; $display("FAIL timeout_polls got %0d want 10", poll_n); end
        checks++;
        if (err !== 2'd2) begin errors++; $display("FAIL timeout_err got %0d want 2", err); end
        checks++;
        if ({csb_req, n25q_write_mode, n25q_read_mode} !== 3'b100) begin
            errors++; $display("FAIL timeout_idle got %b want 100", {csb_req, n25q_write_mode, n25q_read_mode});
        end
        wip_busy = 2;
    endtask

    task automatic test_back_to_back_rd;
        logic ok;
        clear_logs();
        send_cmd(1'b0, 24'h000200, 9'd8);
        run(3000, 0, 8'h00, 1'b1, ok);
        checks++;
        if (!ok || err !== 2'd0) begin errors++; $display("FAIL bp_done got ok=%b err=%0d want 1/0", ok, err); end
        checks++;
        if (rq.size() != 8) begin errors++; $display("FAIL bp_count got %0d want 8", rq.size()); end
        else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (rq[i] !== mem(24'h000200 + 24'(i))) begin
                    errors++; $display("FAIL bp_byte%0d got %h want %h", i, rq[i], mem(24'h000200 + 24'(i)));
                end
            end
        end
        checks++;
        if (rdq_cons.size() != 2 || rdq_cons[0] != 0 || rdq_cons[1] != 4) begin
            errors++; $display("FAIL bp_read_gating got n=%0d consumed_at_2nd=%0d want 2/4", rdq_cons.size(), rdq_cons[1]);
        end
        checks++;
        if (proto_err != 0) begin errors++; $display("FAIL bp_protocol got %0d violations want 0", proto_err); end
    endtask

    task automatic test_reset_mid;
        logic ok;
        clear_logs();
        send_cmd(1'b1, 24'h000300, 9'd8);
        ok = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge ifclk);
            if (wr_acc_cnt < 2) begin
                wr_valid = 1'b1;
                wr_data  = 8'hA0 + 8'(wr_acc_cnt);
            end else begin
                wr_valid = 1'b0;
                ok = 1'b1;
                break;
            end
        end
        wr_valid = 1'b0;
        checks++;
        if (!ok || csb_req !== 1'b0 || n25q_write_mode !== 1'b1) begin
            errors++; $display("FAIL rstmid_pre got ok=%b csb=%b wm=%b want 1/0/1", ok, csb_req, n25q_write_mode);
        end
        resetb = 1'b0;
        #1;
        checks++;
        if ({csb_req, n25q_write_mode, n25q_read_mode, wr_ready} !== 4'b1000) begin
            errors++; $display("FAIL rstmid_abort got %b want 1000", {csb_req, n25q_write_mode, n25q_read_mode, wr_ready});
        end
        @(negedge ifclk);
        resetb = 1'b1;
        @(negedge ifclk);
        checks++;
        if (cmd_ready !== 1'b1 || csb_req !== 1'b1 || err !== 2'd0) begin
            errors++; $display("FAIL rstmid_release got ready=%b csb=%b err=%0d want 1/1/0", cmd_ready, csb_req, err);
        end
    endtask

    initial begin
        test_reset();
        test_read();
        test_program();
        test_bad_len();
        test_poll_timeout();
        test_back_to_back_rd();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/n25q_seq.md
Name: n25q_seq

Overview:
- Command sequencer directly upstream of the N25Q SPI shifter; masters its data-terminal handshake in place of the host DI bus.
- Turns byte-level host requests (READ, PAGE PROGRAM) into N25Q opcode/address/data phases, packed into 32-bit words, LSB byte first on the wire.
- PAGE PROGRAM runs WRITE ENABLE (0x06), PAGE PROGRAM (0x02), then polls READ STATUS (0x05) until WIP = 0.

Parameters:
- CS_GAP, 4: ifclk cycles csb_req stays high between chip-select phases (min 1).
- POLL_MAX, 200000: status polls before timeout error (32-bit).

Ports:
- ifclk  in  1  clock
- resetb  in  1  async active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  accepting command (high only in IDLE)
- cmd_prog  in  1  0 = READ, 1 = PAGE PROGRAM
- cmd_addr  in  24  flash byte address
- cmd_len  in  9  byte count, legal 1..256
- wr_data  in  8  program byte
- wr_valid  in  1  program byte valid
- wr_ready  out  1  program byte accepted
- rd_data  out  8  read byte
- rd_valid  out  1  read byte valid
- rd_ready  in  1  read byte accepted
- done  out  1  one-cycle pulse at command end
- err  out  2  0 ok, 1 bad length, 2 poll timeout; held until next accepted command
- csb_req  out  1  chip select to flash, active low
- n25q_write_mode  out  1  shifter write-mode level
- n25q_read_mode  out  1  shifter read-mode level
- n25q_write  out  1  one-cycle word-write pulse
- n25q_read_req  out  1  one-cycle word-read pulse
- n25q_len  out  32  total bytes in current csb phase
- n25q_datai  out  32  word to shift; [7:0] goes first
- n25q_rdy  in  1  shifter idle
- n25q_datao  in  32  received word; [7:0] is first byte

Behaviour:
- Reset: cmd_ready=0 then 1 once in IDLE, wr_ready=0, rd_valid=0, rd_data=0, done=0, err=0, csb_req=1, both modes 0, n25q_write=n25q_read_req=0, n25q_len=0, n25q_datai=0. Reset mid-operation aborts immediately and deasserts csb.
- Handshakes: valid/ready transfer when both high at a clock edge. Command is captured on the accepting cycle. cmd_len 0 or >256 -> err=1, done pulse next cycle, no flash traffic.
- Word issue: at most one n25q_write or n25q_read_req pulse at a time. After a pulse, ignore n25q_rdy for 1 cycle, then wait for n25q_rdy=1 before the next pulse. Mode is held for the whole csb phase: write_mode for opcode/address/program words, read_mode for read data and status words. Drop both modes and raise csb_req for CS_GAP cycles between phases. n25q_len is held constant during a phase.
- States:
  - IDLE
  - WREN: 1 byte, 0x06.
  - CMD: 4 bytes {addr[7:0],addr[15:8],addr[23:16],op} sent as datai = {a[7:0],a[15:8],a[23:16],op}, so op goes first and the address is MSB first.
  - DATA_W: pack up to 4 wr bytes (first byte in [7:0]); the final partial word is issued as-is.
  - DATA_R: datai=0xFFFFFFFF; unpack datao bytes in order to rd_*; stall while rd_ready=0; issue the next read only after all bytes of the current word are consumed.
  - POLL: phase len 2 in write then read mode; send 0x05, then read the status byte.
  - GAP
  - FINISH
- READ: CMD (op 0x03, phase len 4+cmd_len; mode switches to read after the command word, same csb) -> DATA_R -> FINISH.
- PROGRAM: WREN -> GAP -> CMD (op 0x02, len 4+cmd_len) -> DATA_W -> GAP -> POLL, repeated while status[0]=1, with GAP between polls -> FINISH.
- Poll count hitting POLL_MAX -> err=2, FINISH.
- FINISH: csb_req=1, modes 0, done pulse, return to IDLE.
- wr_ready is high only in DATA_W while the pack buffer is not full. Bytes beyond cmd_len are never accepted.
- Length counter is 9 bits; the last word holds (len mod 4, or 4) bytes.

Optional Feature:
- N25Q_SEQ_FAST_READ_EN
  - Defined: READ uses op 0x0B plus one dummy byte. Command phase is 5 bytes: word {a,a,a,0x0B} then a 1-byte 0xFF dummy word. Phase len = 5+cmd_len; dummy byte discarded.
  - Undefined: op 0x03, no dummy.

Test Plan:
- READ addr 0x123456 len 6 -> csb low once; first word 0x56341203; rd bytes match flash model; done pulse, err=0.
- PROGRAM addr 0x000100 len 5, bytes 11..15 -> 0x06 phase, gap>=CS_GAP, word 0x00010002 then 0x14131211 and 0x00000015 (len 9); polls until WIP clears after 3 polls; done, err=0.
- PROGRAM with model WIP stuck 1, POLL_MAX=10 -> exactly 10 polls, err=2, csb_req=1.
- cmd_len=0 and cmd_len=257 -> err=1, no csb activity, done pulse.
- READ len 8 with rd_ready toggling 1/0 -> no byte lost or duplicated; second read pulse only after 4 bytes consumed.
- resetb low during DATA_W -> csb_req=1, modes 0, cmd_ready=1 after release.
